// File: rtl/fp_mul_round.sv
// Normalise, round-to-nearest-even and pack stage behind the binary32 mantissa multiplier.
// Two registered stages (s1 = normalised fields, out = packed result) with valid/ready on both sides.
module fp_mul_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_prod,
    input  logic [1:0]  in_class,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);
    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;
    localparam logic [1:0] CLS_NAN    = 2'b11;

    localparam logic signed [9:0] EXP_MAX = 10'sd255;
    localparam logic signed [9:0] EXP_MIN = 10'sd0;

    // Handshake: a bundle moves on in_valid & in_ready, a result leaves on out_valid & out_ready;
    // a stage advances when it is empty or the stage after it is advancing.
    logic adv1;
    logic adv2;
    logic accept;

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [9:0]  s1_exp_q, s1_exp_d;
    logic [22:0] s1_mant_q, s1_mant_d;
    logic        s1_guard_q, s1_guard_d;
    logic        s1_sticky_q, s1_sticky_d;
    logic [1:0]  s1_class_q, s1_class_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [2:0]  out_flags_q, out_flags_d;

    logic        round_up;
    logic [23:0] mant_sum;
    logic signed [9:0] exp_rnd;
    logic [31:0] packed_res;
    logic [2:0]  packed_flags;

    assign adv2     = ~out_valid_q | out_ready;
    assign adv1     = ~s1_valid_q | adv2;
    assign in_ready = adv1;
    assign accept   = in_valid & adv1;

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    // Stage 1: pick the leading one at bit 47 or bit 46 and split off guard/sticky.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sign_d   = s1_sign_q;
        s1_exp_d    = s1_exp_q;
        s1_mant_d   = s1_mant_q;
        s1_guard_d  = s1_guard_q;
        s1_sticky_d = s1_sticky_q;
        s1_class_d  = s1_class_q;
        if (adv1) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_sign_d  = in_sign;
            s1_class_d = in_class;
            if (in_prod[47]) begin
                s1_mant_d   = in_prod[46:24];
                s1_guard_d  = in_prod[23];
                s1_sticky_d = |in_prod[22:0];
                s1_exp_d    = in_exp + 10'd1;
            end else begin
                s1_mant_d   = in_prod[45:23];
                s1_guard_d  = in_prod[22];
                s1_sticky_d = |in_prod[21:0];
                s1_exp_d    = in_exp;
            end
        end
    end

    // Stage 2: round to nearest even; a mantissa carry wraps m to zero and bumps the exponent.
    always_comb begin
        round_up = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
        mant_sum = {1'b0, s1_mant_q} + {23'd0, round_up};
        exp_rnd  = $signed(s1_exp_q) + $signed({9'd0, mant_sum[23]});

        packed_res   = {s1_sign_q, exp_rnd[7:0], mant_sum[22:0]};
        packed_flags = {2'b00, s1_guard_q | s1_sticky_q};
        if (s1_class_q == CLS_NAN) begin
            packed_res   = 32'h7FC0_0000;
            packed_flags = 3'b000;
        end else if (s1_class_q == CLS_INF) begin
            packed_res   = {s1_sign_q, 8'hFF, 23'd0};
            packed_flags = 3'b000;
        end else if (s1_class_q == CLS_ZERO) begin
            packed_res   = {s1_sign_q, 31'd0};
            packed_flags = 3'b000;
        end else if (exp_rnd >= EXP_MAX) begin
            packed_res   = {s1_sign_q, 8'hFF, 23'd0};
            packed_flags = 3'b101;
        end else if (exp_rnd <= EXP_MIN) begin
            packed_res   = {s1_sign_q, 31'd0};
            packed_flags = 3'b011;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = packed_res;
                out_flags_d  = packed_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 10'd0;
            s1_mant_q    <= 23'd0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_class_q   <= CLS_NORMAL;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_flags_q  <= 3'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_mant_q    <= s1_mant_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_class_q   <= s1_class_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end
endmodule

// File: tb/tb_fp_mul_round.sv
// Bench for fp_mul_round: directed spec cases, stall/reset sequences, then random traffic
// against an arithmetic round-to-nearest-even reference with an expected-result queue.
module tb_fp_mul_round;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  in_class;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int vectors = 0;
  int miscompares = 0;
  int n_out = 0;
  logic rnd_bp = 1'b0;
  logic [34:0] exp_q[$];

  fp_mul_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: value = prod / 2^sh with the remainder deciding round-to-nearest-even.
  function automatic logic [34:0] model(input logic s, input logic [9:0] e_in,
                                        input logic [47:0] p, input logic [1:0] c);
    longint unsigned pv;
    longint unsigned q;
    longint unsigned r;
    longint unsigned half;
    int sh;
    int e;
    logic inexact;
    pv = p;
    sh = p[47] ? 24 : 23;
    q = pv >> sh;
    r = pv - (q << sh);
    half = 64'd1 << (sh - 1);
    e = int'($signed(e_in)) + (p[47] ? 1 : 0);
    inexact = (r != 0);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q >= 64'd16777216) begin
      q = q >> 1;
      e = e + 1;
    end
    if (c == 2'b11) return {32'h7FC00000, 3'b000};
    if (c == 2'b10) return {s, 8'hFF, 23'd0, 3'b000};
    if (c == 2'b01) return {s, 31'd0, 3'b000};
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b101};
    if (e <= 0) return {s, 31'd0, 3'b011};
    return {s, 8'(e), 23'(q), 2'b00, inexact};
  endfunction

  // Present a bundle from posedge+1, wait for acceptance, return at posedge+1 after the capture edge.
  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                      input logic [1:0] c, input logic [34:0] expv);
    int budget = 0;
    logic ok = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_prod = p; in_class = c;
    while (!ok && budget < 60) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else budget++;
    end
    if (ok) exp_q.push_back(expv);
    else chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pop on every consumed result, and hold check across stalled edges.
  logic        hold_prev = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_flags;
  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", 64'(out_result), 64'(prev_res));
        chk("hold_flags", 64'(out_flags), 64'(prev_flags));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(out_result), 64'(e[34:3]));
          chk("flags", 64'(out_flags), 64'(e[2:0]));
        end
      end
      hold_prev  = out_valid && !out_ready;
      prev_res   = out_result;
      prev_flags = out_flags;
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int base;
    logic        rs;
    logic [9:0]  re;
    logic [47:0] rp;
    logic [1:0]  rc;
    int          pick;

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = 10'd0;
    in_prod = 48'd0; in_class = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 2.25 with latency probe: s1 only after capture, out register one edge later.
    send(1'b0, 10'd127, 48'h900000000000, 2'b00, {32'h40100000, 3'b000});
    chk("lat_s1_only", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_out", 64'(out_valid), 64'd1);
    chk("lat_value", 64'(out_result), 64'h40100000);

    send(1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, {32'h40000000, 3'b001});
    send(1'b0, 10'd127, 48'h400000400000, 2'b00, {32'h3F800000, 3'b001});
    send(1'b0, 10'd127, 48'h400000C00000, 2'b00, {32'h3F800002, 3'b001});
    send(1'b1, 10'd254, 48'h800000000000, 2'b00, {32'hFF800000, 3'b101});
    send(1'b0, 10'd0,   48'h400000000000, 2'b00, {32'h00000000, 3'b011});
    send(1'b1, 10'd127, 48'h400000000000, 2'b11, {32'h7FC00000, 3'b000});
    send(1'b1, 10'd127, 48'h400000000000, 2'b10, {32'hFF800000, 3'b000});
    send(1'b1, 10'd127, 48'h400000000000, 2'b01, {32'h80000000, 3'b000});
    drain();

    // Backpressure: two accepted, then in_ready low and the head result held.
    base = n_out;
    out_ready = 1'b0;
    send(1'b0, 10'd127, 48'h900000000000, 2'b00, {32'h40100000, 3'b000});
    send(1'b0, 10'd127, 48'hC00000000000, 2'b00, {32'h40400000, 3'b000});
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd128; in_prod = 48'h800000000000; in_class = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_out_result", 64'(out_result), 64'h40100000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(1'b0, 10'd128, 48'h800000000000, 2'b00, {32'h40800000, 3'b000});
    send(1'b1, 10'd126, 48'h600000000000, 2'b00, {32'hBF400000, 3'b000});
    drain();
    chk("stall_count", 64'(n_out - base), 64'd4);

    // Reset while stalled with both stages full.
    out_ready = 1'b0;
    send(1'b0, 10'd130, 48'h900000000000, 2'b00, {32'h41900000, 3'b000});
    send(1'b0, 10'd131, 48'h900000000000, 2'b00, {32'h42100000, 3'b000});
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_result", 64'(out_result), 64'd0);
    chk("midrst_out_flags", 64'(out_flags), 64'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(1'b0, 10'd127, 48'h900000000000, 2'b00, {32'h40100000, 3'b000});
    drain();

    // Random traffic under random backpressure.
    rnd_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rs = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      if (pick < 5) re = 10'($urandom_range(0, 510) - 127);
      else if (pick < 8) re = 10'($urandom_range(118, 136));
      else re = 10'($urandom_range(0, 1) ? $urandom_range(252, 256) : $urandom_range(0, 3) - 1);
      rp = {16'($urandom), $urandom};
      if (!rp[47]) rp[46] = 1'b1;
      pick = $urandom_range(0, 5);
      if (pick == 0) rp[22:0] = 23'd0;
      else if (pick == 1) rp[45:23] = 23'h7FFFFF;
      pick = $urandom_range(0, 11);
      rc = (pick < 9) ? 2'b00 : 2'($urandom_range(1, 3));
      send(rs, re, rp, rc, model(rs, re, rp, rc));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
